// File: rtl/sevenseg_pkg.sv
// Shared types and constants for the seven-segment scan driver.
// Segment vectors are ordered GFEDCBA (bit 6 = G, bit 0 = A).
package sevenseg_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK_N = 7'h7F;
  localparam seg_t SEG_BLANK   = 7'h00;

  typedef enum logic {
    DEAD  = 1'b0,
    DRIVE = 1'b1
  } scan_state_t;

endpackage

// File: rtl/digits_to_segments.sv
// Hex nibble to active-low GFEDCBA segment pattern; purely combinational.
// Latency: none; backpressure: none.
module digits_to_segments
  import sevenseg_pkg::*;
(
  input  logic [3:0] digit,
  output seg_t       segs_n
);

  always_comb begin
    segs_n = SEG_BLANK_N;
    case (digit)
      4'h0: segs_n = 7'h40;
      4'h1: segs_n = 7'h79;
      4'h2: segs_n = 7'h24;
      4'h3: segs_n = 7'h30;
      4'h4: segs_n = 7'h19;
      4'h5: segs_n = 7'h12;
      4'h6: segs_n = 7'h02;
      4'h7: segs_n = 7'h78;
      4'h8: segs_n = 7'h00;
      4'h9: segs_n = 7'h10;
      4'hA: segs_n = 7'h08;
      4'hB: segs_n = 7'h03;
      4'hC: segs_n = 7'h46;
      4'hD: segs_n = 7'h21;
      4'hE: segs_n = 7'h06;
      4'hF: segs_n = 7'h0E;
      default: segs_n = SEG_BLANK_N;
    endcase
  end

endmodule

// File: rtl/sevenseg_scan_driver.sv
// Time-multiplexed N-digit seven-segment scan driver with dead time and frame-synchronous shadowing; SEVSEG_LZB_EN adds leading-zero blanking.
// Latency: all outputs registered (one cycle behind the scan state); backpressure: none, load is accepted every cycle.
module sevenseg_scan_driver
  import sevenseg_pkg::*;
#(
  parameter int NUM_DIGITS        = 4,
  parameter int REFRESH_DIV       = 100000,
  parameter int DEAD_CYCLES       = 1000,
  parameter bit ACTIVE_LOW_SEGS   = 1'b1,
  parameter bit ACTIVE_LOW_ANODES = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    load,
  output seg_t                    segs,
  output logic                    dp_o,
  output logic [NUM_DIGITS-1:0]   anodes,
  output logic                    frame_done
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CW-1:0]         CNT_MAX  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0]         DEAD_LIM = CW'(DEAD_CYCLES);
  localparam logic [IW-1:0]         IDX_MAX  = IW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AN_OFF   = {NUM_DIGITS{ACTIVE_LOW_ANODES}};
  localparam seg_t                  SEG_OFF  = ACTIVE_LOW_SEGS ? SEG_BLANK_N : SEG_BLANK;
  localparam logic                  DP_OFF   = ACTIVE_LOW_SEGS;

  logic [CW-1:0] cnt, cnt_nxt;
  logic [IW-1:0] idx, idx_nxt;
  logic          slot_wrap;
  logic          frame_wrap;
  logic          first;
  logic          frame_load;

  scan_state_t   state, state_nxt;

  logic [4*NUM_DIGITS-1:0] pend_val, sh_val;
  logic [NUM_DIGITS-1:0]   pend_dp,  sh_dp;
  logic [NUM_DIGITS-1:0]   pend_en,  sh_en;
  logic [NUM_DIGITS-1:0]   eff_en;

  logic [3:0]              cur_digit;
  seg_t                    dec_n;
  logic                    lit;
  logic [NUM_DIGITS-1:0]   onehot;
  seg_t                    segs_nxt;
  logic                    dp_nxt;
  logic [NUM_DIGITS-1:0]   anodes_nxt;

  // Slot counter and digit index
  always_comb begin
    slot_wrap  = (cnt == CNT_MAX);
    frame_wrap = slot_wrap && (idx == IDX_MAX);
    cnt_nxt    = slot_wrap ? '0 : cnt + 1'b1;
    idx_nxt    = idx;
    if (slot_wrap) begin
      idx_nxt = (idx == IDX_MAX) ? '0 : idx + 1'b1;
    end
    frame_load = frame_wrap || first;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      idx   <= '0;
      first <= 1'b1;
    end else begin
      cnt   <= cnt_nxt;
      idx   <= idx_nxt;
      first <= 1'b0;
    end
  end

  // State tracks the phase of the counter value it is registered with
  always_comb begin
    state_nxt = state;
    case (state)
      DEAD:    if (cnt_nxt >= DEAD_LIM) state_nxt = DRIVE;
      DRIVE:   if (cnt_nxt <  DEAD_LIM) state_nxt = DEAD;
      default: state_nxt = DEAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= DEAD;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_val <= '0;
      pend_dp  <= '0;
      pend_en  <= '0;
    end else if (load) begin
      pend_val <= value;
      pend_dp  <= dp;
      pend_en  <= digit_en;
    end
  end

  // Shadow only moves at the frame boundary so a frame never tears
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_val <= '0;
      sh_dp  <= '0;
      sh_en  <= '0;
    end else if (frame_load) begin
      sh_val <= pend_val;
      sh_dp  <= pend_dp;
      sh_en  <= pend_en;
    end
  end

`ifdef SEVSEG_LZB_EN
  logic [NUM_DIGITS-1:0] lzb_mask_nxt, lzb_mask;
  logic                  leading;

  // Mask is derived from the data about to enter the shadow, so both land together
  always_comb begin
    lzb_mask_nxt = '0;
    leading      = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      if (leading && (pend_val[4*i +: 4] == 4'h0)) begin
        lzb_mask_nxt[i] = 1'b1;
      end else begin
        leading = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lzb_mask <= '0;
    end else if (frame_load) begin
      lzb_mask <= lzb_mask_nxt;
    end
  end

  assign eff_en = sh_en & ~lzb_mask;
`else
  assign eff_en = sh_en;
`endif

  assign cur_digit = sh_val[{idx, 2'b00} +: 4];

  digits_to_segments u_dec (
    .digit  (cur_digit),
    .segs_n (dec_n)
  );

  always_comb begin
    lit        = (state == DRIVE) && eff_en[idx];
    onehot     = lit ? (NUM_DIGITS'(1) << idx) : '0;
    anodes_nxt = ACTIVE_LOW_ANODES ? ~onehot : onehot;
    segs_nxt   = SEG_OFF;
    dp_nxt     = DP_OFF;
    if (lit) begin
      segs_nxt = ACTIVE_LOW_SEGS ? dec_n : ~dec_n;
      dp_nxt   = ACTIVE_LOW_SEGS ? ~sh_dp[idx] : sh_dp[idx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      anodes     <= AN_OFF;
      segs       <= SEG_OFF;
      dp_o       <= DP_OFF;
      frame_done <= 1'b0;
    end else begin
      anodes     <= anodes_nxt;
      segs       <= segs_nxt;
      dp_o       <= dp_nxt;
      frame_done <= frame_wrap;
    end
  end

endmodule
